game_fsm_v2: RTL and testbench

Parametrised next-generation top-level game-flow controller for the STG game. It sequences intro, title, play, hit-invulnerability, bomb, pause, success and game-over phases. It tracks life and bomb stocks with pickup support and saturation, and drives game enable and game reset for the rest of the game datapath (player, enemy, bullet and render blocks).

---
 rtl/game_fsm_v2.sv | 228 ++++++++++++++++++++++
 tb/tb_game_fsm_v2.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_v2.sv
// game_fsm_v2: STG game-flow controller (intro/title/play/hit/bomb/pause/end phases)
// with life/bomb stock tracking and datapath enable/reset generation. Rev 1.0
`default_nettype none

module game_fsm_v2 #(
  parameter int CNT_W       = 4,
  parameter int LIFE_INIT   = 3,
  parameter int BOMB_INIT   = 3,
  parameter int LIFE_MAX    = 9,
  parameter int BOMB_MAX    = 9,
  parameter int TMR_W       = 32,
  parameter int INTRO_TICKS = 20000000,
  parameter int HIT_TICKS   = 20000000,
  parameter int BOMB_TICKS  = 40000000
) (
  input  logic             clk,
  input  logic             hard_reset_n,
  input  logic             enter_i,
  input  logic             bomb_i,
  input  logic             pause_i,
  input  logic             collision_i,
  input  logic             die_i,
  input  logic             life_up_i,
  input  logic             bomb_up_i,
  output logic [CNT_W-1:0] num_life_o,
  output logic [CNT_W-1:0] num_bomb_o,
  output logic [3:0]       game_state_o,
  output logic             game_en_o,
  output logic             game_reset_o,
  output logic             invuln_o
);

  typedef enum logic [3:0] {
    S_INIT     = 4'b0000,
    S_START    = 4'b0001,
    S_PLAY     = 4'b0010,
    S_PAUSE    = 4'b0011,
    S_BOMB     = 4'b0110,
    S_HIT      = 4'b1010,
    S_SUCCESS  = 4'b1000,
    S_GAMEOVER = 4'b1001
  } state_t;

  localparam logic [TMR_W-1:0] C_INTRO_T = TMR_W'(INTRO_TICKS);
  localparam logic [TMR_W-1:0] C_HIT_T   = TMR_W'(HIT_TICKS);
  localparam logic [TMR_W-1:0] C_BOMB_T  = TMR_W'(BOMB_TICKS);
  localparam logic [CNT_W-1:0] C_LIFE_I  = CNT_W'(LIFE_INIT);
  localparam logic [CNT_W-1:0] C_BOMB_I  = CNT_W'(BOMB_INIT);
  localparam logic [CNT_W-1:0] C_LIFE_M  = CNT_W'(LIFE_MAX);
  localparam logic [CNT_W-1:0] C_BOMB_M  = CNT_W'(BOMB_MAX);

  state_t             state_q, state_d;
  state_t             saved_q, saved_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   life_q, life_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic               en_q, en_d;
  logic               greset_q, greset_d;
  logic               invuln_q, invuln_d;
  logic               enter_q, bomb_q, pause_q;

  logic enter_pe, bomb_pe, pause_pe;
  logic life_dec, bomb_dec, life_block, load_init;
  logic pickup_ok, life_inc, bomb_inc;

  assign enter_pe = enter_i & ~enter_q;
  assign bomb_pe  = bomb_i  & ~bomb_q;
  assign pause_pe = pause_i & ~pause_q;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    timer_d    = timer_q;
    en_d       = en_q;
    greset_d   = 1'b0;
    life_dec   = 1'b0;
    bomb_dec   = 1'b0;
    life_block = 1'b0;
    load_init  = 1'b0;

    case (state_q)
      S_INIT: begin
        if (timer_q == '0) state_d = S_START;
        else               timer_d = timer_q - TMR_W'(1);
      end
      S_START: begin
        if (enter_pe) begin
          state_d  = S_PLAY;
          en_d     = 1'b1;
          greset_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (pause_pe) begin
          state_d = S_PAUSE;
          saved_d = S_PLAY;
          en_d    = 1'b0;
        end else if (die_i) begin
          state_d = S_SUCCESS;
          en_d    = 1'b0;
        end else if (collision_i) begin
          if (life_q == '0) begin
            state_d    = S_GAMEOVER;
            en_d       = 1'b0;
            life_block = 1'b1;
          end else begin
            life_dec = 1'b1;
            state_d  = S_HIT;
            timer_d  = C_HIT_T;
          end
        end else if (bomb_pe && bcnt_q != '0) begin
          bomb_dec = 1'b1;
          state_d  = S_BOMB;
          timer_d  = C_BOMB_T;
        end
      end
      S_HIT: begin
        if (pause_pe) begin
          state_d = S_PAUSE;
          saved_d = S_HIT;
          en_d    = 1'b0;
        end else if (die_i) begin
          state_d = S_SUCCESS;
          en_d    = 1'b0;
        end else if (bomb_pe && bcnt_q != '0) begin
          bomb_dec = 1'b1;
          state_d  = S_BOMB;
          timer_d  = C_BOMB_T;
        end else if (timer_q == '0) begin
          state_d = S_PLAY;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_BOMB: begin
        if (pause_pe) begin
          state_d = S_PAUSE;
          saved_d = S_BOMB;
          en_d    = 1'b0;
        end else if (die_i) begin
          state_d = S_SUCCESS;
          en_d    = 1'b0;
        end else if (timer_q == '0) begin
          state_d = S_PLAY;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      // Timer is simply not touched here, so it resumes where it froze.
      S_PAUSE: begin
        if (pause_pe) begin
          state_d = saved_q;
          en_d    = 1'b1;
        end
      end
      S_SUCCESS, S_GAMEOVER: begin
        if (enter_pe) begin
          state_d   = S_INIT;
          timer_d   = C_INTRO_T;
          en_d      = 1'b0;
          greset_d  = 1'b1;
          load_init = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
        timer_d = C_INTRO_T;
        en_d    = 1'b0;
      end
    endcase

    pickup_ok = (state_q == S_PLAY) || (state_q == S_HIT) || (state_q == S_BOMB);
    life_inc  = life_up_i & pickup_ok & ~life_block;
    bomb_inc  = bomb_up_i & pickup_ok;

    // A pickup and a decrement in the same cycle cancel out.
    if (load_init)                 life_d = C_LIFE_I;
    else if (life_inc && !life_dec) life_d = (life_q >= C_LIFE_M) ? life_q : life_q + CNT_W'(1);
    else if (life_dec && !life_inc) life_d = life_q - CNT_W'(1);
    else                            life_d = life_q;

    if (load_init)                 bcnt_d = C_BOMB_I;
    else if (bomb_inc && !bomb_dec) bcnt_d = (bcnt_q >= C_BOMB_M) ? bcnt_q : bcnt_q + CNT_W'(1);
    else if (bomb_dec && !bomb_inc) bcnt_d = bcnt_q - CNT_W'(1);
    else                            bcnt_d = bcnt_q;

    invuln_d = (state_d == S_HIT) || (state_d == S_BOMB) ||
               ((state_d == S_PAUSE) && ((saved_d == S_HIT) || (saved_d == S_BOMB)));
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q  <= S_INIT;
      saved_q  <= S_PLAY;
      timer_q  <= C_INTRO_T;
      life_q   <= C_LIFE_I;
      bcnt_q   <= C_BOMB_I;
      en_q     <= 1'b0;
      greset_q <= 1'b0;
      invuln_q <= 1'b0;
      enter_q  <= 1'b0;
      bomb_q   <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      timer_q  <= timer_d;
      life_q   <= life_d;
      bcnt_q   <= bcnt_d;
      en_q     <= en_d;
      greset_q <= greset_d;
      invuln_q <= invuln_d;
      enter_q  <= enter_i;
      bomb_q   <= bomb_i;
      pause_q  <= pause_i;
    end
  end

  assign num_life_o   = life_q;
  assign num_bomb_o   = bcnt_q;
  assign game_state_o = state_q;
  assign game_en_o    = en_q;
  assign game_reset_o = greset_q;
  assign invuln_o     = invuln_q;

endmodule

`default_nettype wire

// File: tb/tb_game_fsm_v2.sv
// tb_game_fsm_v2: directed scenario bench for game_fsm_v2 with short phase timers.
`default_nettype none

module tb_game_fsm_v2;

  localparam logic [3:0] ST_INIT = 4'h0, ST_START = 4'h1, ST_PLAY = 4'h2, ST_PAUSE = 4'h3;
  localparam logic [3:0] ST_BOMB = 4'h6, ST_HIT = 4'hA, ST_SUCC = 4'h8, ST_GOVER = 4'h9;

  logic       clk, hard_reset_n;
  logic       enter, bomb, pause, collision, die, life_up, bomb_up;
  logic [3:0] num_life, num_bomb, game_state;
  logic       game_en, game_reset, invuln;
  logic [14:0] obs, exp;
  int          n_checks, n_fail;

  game_fsm_v2 #(
    .CNT_W(4), .LIFE_INIT(3), .BOMB_INIT(3), .LIFE_MAX(9), .BOMB_MAX(9), .TMR_W(32),
    .INTRO_TICKS(4), .HIT_TICKS(5), .BOMB_TICKS(8)
  ) dut (
    .clk(clk), .hard_reset_n(hard_reset_n),
    .enter_i(enter), .bomb_i(bomb), .pause_i(pause), .collision_i(collision),
    .die_i(die), .life_up_i(life_up), .bomb_up_i(bomb_up),
    .num_life_o(num_life), .num_bomb_o(num_bomb), .game_state_o(game_state),
    .game_en_o(game_en), .game_reset_o(game_reset), .invuln_o(invuln)
  );

  assign obs = {game_state, num_life, num_bomb, game_en, game_reset, invuln};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builder: {state, lives, bombs, game_en, game_reset, invuln}
  function automatic logic [14:0] pk(input logic [3:0] st, input int l, input int b,
                                     input logic en, input logic rs, input logic iv);
    return {st, 4'(l), 4'(b), en, rs, iv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    hard_reset_n = 1'b0;
    {enter, bomb, pause, collision, die, life_up, bomb_up} = '0;
    repeat (3) tick();
    exp = pk(ST_INIT, 3, 3, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs, exp); end
    hard_reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp = pk(ST_INIT, 3, 3, 0, 0, 0); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL intro_dwell[%0d]: got %h expected %h", i, obs, exp); end
    end
    tick();
    exp = pk(ST_START, 3, 3, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL intro_exit: got %h expected %h", obs, exp); end
  endtask

  task automatic test_start();
    enter = 1'b1;
    tick();
    exp = pk(ST_PLAY, 3, 3, 1, 1, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL start_enter: got %h expected %h", obs, exp); end
    for (int i = 0; i < 9; i++) begin
      tick();
      exp = pk(ST_PLAY, 3, 3, 1, 0, 0); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL start_held[%0d]: got %h expected %h", i, obs, exp); end
    end
    enter = 1'b0;
    tick();
  endtask

  task automatic test_hit();
    collision = 1'b1;
    tick();
    exp = pk(ST_HIT, 2, 3, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL hit_enter: got %h expected %h", obs, exp); end
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) collision = 1'b0;
      tick();
      exp = pk(ST_HIT, 2, 3, 1, 0, 1); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL hit_hold[%0d]: got %h expected %h", i, obs, exp); end
    end
    tick();
    exp = pk(ST_PLAY, 2, 3, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL hit_exit: got %h expected %h", obs, exp); end
  endtask

  task automatic test_hit_to_bomb();
    collision = 1'b1; tick(); collision = 1'b0;
    exp = pk(ST_HIT, 1, 3, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL h2b_hit: got %h expected %h", obs, exp); end
    tick();
    bomb = 1'b1; tick(); bomb = 1'b0;
    exp = pk(ST_BOMB, 1, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL h2b_bomb: got %h expected %h", obs, exp); end
    tick();
    bomb = 1'b1; collision = 1'b1; tick(); bomb = 1'b0; collision = 1'b0;
    exp = pk(ST_BOMB, 1, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bomb_ignores: got %h expected %h", obs, exp); end
    repeat (6) tick();
    exp = pk(ST_BOMB, 1, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bomb_last: got %h expected %h", obs, exp); end
    tick();
    exp = pk(ST_PLAY, 1, 2, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bomb_exit: got %h expected %h", obs, exp); end
  endtask

  task automatic test_gameover_restart();
    collision = 1'b1; tick(); collision = 1'b0;
    exp = pk(ST_HIT, 0, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL drain_hit: got %h expected %h", obs, exp); end
    repeat (6) tick();
    exp = pk(ST_PLAY, 0, 2, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL drain_play: got %h expected %h", obs, exp); end
    collision = 1'b1; life_up = 1'b1; tick(); collision = 1'b0; life_up = 1'b0;
    exp = pk(ST_GOVER, 0, 2, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL gameover: got %h expected %h", obs, exp); end
    tick();
    exp = pk(ST_GOVER, 0, 2, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL gameover_hold: got %h expected %h", obs, exp); end
    enter = 1'b1; tick();
    exp = pk(ST_INIT, 3, 3, 0, 1, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart: got %h expected %h", obs, exp); end
    tick();
    exp = pk(ST_INIT, 3, 3, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_pulse_end: got %h expected %h", obs, exp); end
    enter = 1'b0;
    repeat (3) tick();
    exp = pk(ST_INIT, 3, 3, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_intro: got %h expected %h", obs, exp); end
    tick();
    exp = pk(ST_START, 3, 3, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_start: got %h expected %h", obs, exp); end
    enter = 1'b1; tick(); enter = 1'b0;
    exp = pk(ST_PLAY, 3, 3, 1, 1, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_play: got %h expected %h", obs, exp); end
  endtask

  task automatic test_bomb_pause();
    bomb = 1'b1; tick(); bomb = 1'b0;
    exp = pk(ST_BOMB, 3, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bp_bomb: got %h expected %h", obs, exp); end
    repeat (6) tick();
    pause = 1'b1; tick(); pause = 1'b0;
    exp = pk(ST_PAUSE, 3, 2, 0, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bp_pause: got %h expected %h", obs, exp); end
    {enter, bomb, collision, die, life_up, bomb_up} = '1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = pk(ST_PAUSE, 3, 2, 0, 0, 1); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL bp_frozen[%0d]: got %h expected %h", i, obs, exp); end
    end
    {enter, bomb, collision, die, life_up, bomb_up} = '0;
    pause = 1'b1; tick(); pause = 1'b0;
    exp = pk(ST_BOMB, 3, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bp_resume: got %h expected %h", obs, exp); end
    repeat (2) tick();
    exp = pk(ST_BOMB, 3, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bp_remaining: got %h expected %h", obs, exp); end
    tick();
    exp = pk(ST_PLAY, 3, 2, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bp_exit: got %h expected %h", obs, exp); end
  endtask

  task automatic test_pickups();
    collision = 1'b1; tick(); collision = 1'b0;
    repeat (6) tick();
    exp = pk(ST_PLAY, 2, 2, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_setup: got %h expected %h", obs, exp); end
    collision = 1'b1; life_up = 1'b1; tick(); collision = 1'b0; life_up = 1'b0;
    exp = pk(ST_HIT, 2, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_hit_cancel: got %h expected %h", obs, exp); end
    life_up = 1'b1; tick(); life_up = 1'b0;
    exp = pk(ST_HIT, 3, 2, 1, 0, 1); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_life_in_hit: got %h expected %h", obs, exp); end
    repeat (5) tick();
    life_up = 1'b1; repeat (6) tick();
    exp = pk(ST_PLAY, 9, 2, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_life_max: got %h expected %h", obs, exp); end
    tick(); life_up = 1'b0;
    exp = pk(ST_PLAY, 9, 2, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_life_sat: got %h expected %h", obs, exp); end
    bomb_up = 1'b1; repeat (7) tick();
    exp = pk(ST_PLAY, 9, 9, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_bomb_max: got %h expected %h", obs, exp); end
    tick(); bomb_up = 1'b0;
    exp = pk(ST_PLAY, 9, 9, 1, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pk_bomb_sat: got %h expected %h", obs, exp); end
    die = 1'b1; collision = 1'b1; tick(); die = 1'b0; collision = 1'b0;
    exp = pk(ST_SUCC, 9, 9, 0, 0, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL die_over_collision: got %h expected %h", obs, exp); end
    enter = 1'b1; tick(); enter = 1'b0;
    exp = pk(ST_INIT, 3, 3, 0, 1, 0); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL success_restart: got %h expected %h", obs, exp); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_start();
    test_hit();
    test_hit_to_bomb();
    test_gameover_restart();
    test_bomb_pause();
    test_pickups();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
